mc_datapath: RTL and testbench

MC_DATAPATH -- requirements
Module: mc_datapath

---
 rtl/mc_datapath_pkg.sv | 39 +++
 rtl/mc_datapath_if.sv | 42 ++++
 rtl/mc_datapath_shift_add_mul.sv | 68 ++++++
 rtl/mc_datapath.sv | 171 +++++++++++++++++
 tb/tb_mc_datapath.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_pkg
//  Brief    : Shared opcodes, FSM state encoding and flag bundle for the
//             mc_datapath multi-cycle ALU.
//  Revision : 1.0  initial release
// ============================================================================
package datapath_pkg;

    // Opcode encoding
    localparam logic [2:0] c_op_add  = 3'b000;
    localparam logic [2:0] c_op_sub  = 3'b001;
    localparam logic [2:0] c_op_and  = 3'b010;
    localparam logic [2:0] c_op_xor  = 3'b011;
    localparam logic [2:0] c_op_mul  = 3'b100;
    localparam logic [2:0] c_op_sltu = 3'b101;
    localparam logic [2:0] c_op_slts = 3'b110;
    localparam logic [2:0] c_op_rsvd = 3'b111;

    // Controller states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    // Status flags of the last completed operation
    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic illegal;
    } flags_t;

    // Flags after reset: result is 0, so zero is set
    localparam flags_t c_flags_reset = '{zero: 1'b1, carry: 1'b0, ovf: 1'b0, illegal: 1'b0};

endpackage
`default_nettype wire

// File: rtl/mc_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_datapath_if
//  Brief    : Command / load / status bundle of mc_datapath. The master
//             modport issues operations; the slave modport is the datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface mc_datapath_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 4
);
    localparam int AW = $clog2(NREGS);

    logic             start;
    logic [2:0]       op;
    logic [AW-1:0]    addr1;
    logic [AW-1:0]    addr2;
    logic [AW-1:0]    addr3;
    logic             wr;
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             illegal;

    modport master (
        output start, op, addr1, addr2, addr3, wr, ld_en, ld_addr, ld_data,
        input  busy, done, result, zero, carry, ovf, illegal
    );

    modport slave (
        input  start, op, addr1, addr2, addr3, wr, ld_en, ld_addr, ld_data,
        output busy, done, result, zero, carry, ovf, illegal
    );

endinterface
`default_nettype wire

// File: rtl/mc_datapath_shift_add_mul.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mul
//  Brief    : Unsigned shift-add multiplier, one multiplier bit per cycle.
//             start loads the operands; done is asserted combinationally in
//             the final iteration cycle, with product already holding the
//             low WIDTH bits of a*b, so the caller captures it on that edge.
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_mul #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic                  done,
    output logic [WIDTH-1:0]      product
);
    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_active;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_acc_next;

    // Partial product for the current multiplier bit
    always_comb begin
        w_addend   = r_mplier[0] ? r_mcand : '0;
        w_acc_next = r_acc + w_addend;
    end

    assign done    = r_active && (r_cnt == c_last);
    assign product = w_acc_next;

    // Iterate: accumulate, shift multiplicand left and multiplier right
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : mc_datapath
//  Brief    : Multi-cycle ALU with inline register file. Single-cycle ops
//             (ADD/SUB/AND/XOR/SLT/SLTS) complete one cycle after acceptance;
//             MUL runs WIDTH cycles in shift_add_mul.
//  Config   : MC_DATAPATH_MUL_EN -- when defined the multiplier is built;
//             otherwise opcode 100 behaves exactly like the reserved 111.
//  Revision : 1.0  initial release
// ============================================================================
module mc_datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mc_datapath_if.slave bus
);
    localparam int AW  = $clog2(NREGS);
    localparam int MSB = WIDTH - 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [AW-1:0]    r_addr3;
    logic             r_wr;
    logic [WIDTH-1:0] r_result;
    flags_t           r_flags;
    logic             r_done;

    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic             w_is_mul;
    logic             w_accept;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    flags_t           w_alu_flags;
    logic             w_finish;
    logic [WIDTH-1:0] w_fin_res;
    flags_t           w_fin_flags;

    assign w_rd_a   = r_regs[bus.addr1];
    assign w_rd_b   = r_regs[bus.addr2];
    assign w_accept = (r_state == ST_IDLE) && bus.start;

`ifdef MC_DATAPATH_MUL_EN
    assign w_is_mul = (bus.op == c_op_mul);

    // Multiplier takes operands straight from the register file on the accepting edge
    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_accept && w_is_mul),
        .a       (w_rd_a),
        .b       (w_rd_b),
        .done    (w_mul_done),
        .product (w_mul_product)
    );
`else
    assign w_is_mul      = 1'b0;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
`endif

    // Single-cycle ALU on latched operands; unlisted opcodes are illegal
    always_comb begin
        w_sum       = {1'b0, r_a} + {1'b0, r_b};
        w_diff      = r_a - r_b;
        w_alu_res   = '0;
        w_alu_flags = '{zero: 1'b0, carry: 1'b0, ovf: 1'b0, illegal: 1'b0};
        case (r_op)
            c_op_add: begin
                w_alu_res         = w_sum[WIDTH-1:0];
                w_alu_flags.carry = w_sum[WIDTH];
                w_alu_flags.ovf   = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            c_op_sub: begin
                w_alu_res         = w_diff;
                w_alu_flags.carry = (r_a >= r_b);
                w_alu_flags.ovf   = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
            end
            c_op_and:  w_alu_res = r_a & r_b;
            c_op_xor:  w_alu_res = r_a ^ r_b;
            c_op_sltu: w_alu_res = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
            c_op_slts: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            default:   w_alu_flags.illegal = 1'b1;
        endcase
        w_alu_flags.zero = (w_alu_res == '0);
    end

    // Select the completing operation's result and flags
    always_comb begin
        w_finish    = (r_state == ST_EXEC) || ((r_state == ST_MUL) && w_mul_done);
        w_fin_res   = w_alu_res;
        w_fin_flags = w_alu_flags;
        if (r_state == ST_MUL) begin
            w_fin_res   = w_mul_product;
            w_fin_flags = '{zero: (w_mul_product == '0), carry: 1'b0, ovf: 1'b0, illegal: 1'b0};
        end
    end

    // Controller: accept, latch command, complete with registered status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_addr3  <= '0;
            r_wr     <= 1'b0;
            r_result <= '0;
            r_flags  <= c_flags_reset;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= w_rd_a;
                        r_b     <= w_rd_b;
                        r_addr3 <= bus.addr3;
                        r_wr    <= bus.wr;
                        r_state <= w_is_mul ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC, ST_MUL: begin
                    if (w_finish) begin
                        r_result <= w_fin_res;
                        r_flags  <= w_fin_flags;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Register file: direct loads only while idle, write-back on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if ((r_state == ST_IDLE) && bus.ld_en) begin
            r_regs[bus.ld_addr] <= bus.ld_data;
        end else if (w_finish && r_wr && !w_fin_flags.illegal) begin
            r_regs[r_addr3] <= w_fin_res;
        end
    end

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = r_done;
    assign bus.result  = r_result;
    assign bus.zero    = r_flags.zero;
    assign bus.carry   = r_flags.carry;
    assign bus.ovf     = r_flags.ovf;
    assign bus.illegal = r_flags.illegal;

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_datapath
//  Brief    : Directed self-checking bench for mc_datapath (WIDTH=32,
//             NREGS=4); adapts the MUL scenarios to MC_DATAPATH_MUL_EN.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mc_datapath;
    import datapath_pkg::*;

    localparam int WIDTH = 32;
    localparam int NREGS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mc_datapath_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

    mc_datapath #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Advance one clock; inputs changed after this are seen at the next edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a[1:0];
        bus.ld_data = d;
        tick();
        bus.ld_en   = 1'b0;
    endtask

    // Issue an op, scramble inputs after acceptance, count edges until done
    task automatic run_op(input logic [2:0] o, input int a1, input int a2, input int a3,
                          input logic w, input logic poke, output int cyc);
        bus.op    = o;
        bus.addr1 = a1[1:0];
        bus.addr2 = a2[1:0];
        bus.addr3 = a3[1:0];
        bus.wr    = w;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.addr1 = ~a1[1:0];
        bus.addr2 = ~a2[1:0];
        bus.addr3 = ~a3[1:0];
        bus.wr    = ~w;
        cyc = 0;
        while (cyc < 200) begin
            bus.start = poke && (cyc == 5 || cyc == 12);
            tick();
            cyc++;
            if (bus.done === 1'b1) break;
        end
        bus.start = 1'b0;
        bus.wr    = 1'b0;
    endtask

    task automatic read_reg(input int a, output logic [31:0] d);
        int c;
        run_op(c_op_and, a, a, 0, 1'b0, 1'b0, c);
        d = bus.result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
        checks++; if ({bus.zero, bus.carry, bus.ovf, bus.illegal} !== 4'b1000)
            begin errors++; $display("FAIL reset_flags got %b exp 1000", {bus.zero, bus.carry, bus.ovf, bus.illegal}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        int c;
        logic [31:0] d;
        load(1, 32'd7);
        load(2, 32'd5);
        run_op(c_op_add, 1, 2, 3, 1'b1, 1'b0, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL add_latency got %0d exp 1", c); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL add_busy_at_done got %b exp 0", bus.busy); end
        checks++; if (bus.result !== 32'd12) begin errors++; $display("FAIL add_result got %h exp c", bus.result); end
        checks++; if ({bus.zero, bus.carry, bus.ovf, bus.illegal} !== 4'b0000)
            begin errors++; $display("FAIL add_flags got %b exp 0000", {bus.zero, bus.carry, bus.ovf, bus.illegal}); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL add_done_width got %b exp 0", bus.done); end
        read_reg(3, d);
        checks++; if (d !== 32'd12) begin errors++; $display("FAIL add_writeback got %h exp c", d); end
    endtask

    task automatic test_arith_flags();
        int c;
        load(1, 32'd5); load(2, 32'd5);
        run_op(c_op_sub, 1, 2, 0, 1'b0, 1'b0, c);
        checks++; if ({bus.result, bus.zero, bus.carry, bus.ovf} !== {32'd0, 3'b110})
            begin errors++; $display("FAIL sub_equal got %h %b exp 0 110", bus.result, {bus.zero, bus.carry, bus.ovf}); end
        load(1, 32'hFFFF_FFFF); load(2, 32'd1);
        run_op(c_op_add, 1, 2, 0, 1'b0, 1'b0, c);
        checks++; if ({bus.result, bus.zero, bus.carry, bus.ovf} !== {32'd0, 3'b110})
            begin errors++; $display("FAIL add_wrap got %h %b exp 0 110", bus.result, {bus.zero, bus.carry, bus.ovf}); end
        load(1, 32'h7FFF_FFFF);
        run_op(c_op_add, 1, 2, 0, 1'b0, 1'b0, c);
        checks++; if ({bus.result, bus.zero, bus.carry, bus.ovf} !== {32'h8000_0000, 3'b001})
            begin errors++; $display("FAIL add_ovf got %h %b exp 80000000 001", bus.result, {bus.zero, bus.carry, bus.ovf}); end
        load(1, 32'h8000_0000);
        run_op(c_op_sub, 1, 2, 0, 1'b0, 1'b0, c);
        checks++; if ({bus.result, bus.zero, bus.carry, bus.ovf} !== {32'h7FFF_FFFF, 3'b011})
            begin errors++; $display("FAIL sub_ovf got %h %b exp 7fffffff 011", bus.result, {bus.zero, bus.carry, bus.ovf}); end
        load(1, 32'd3); load(2, 32'd9);
        run_op(c_op_sub, 1, 2, 0, 1'b0, 1'b0, c);
        checks++; if ({bus.result, bus.carry, bus.ovf} !== {32'hFFFF_FFFA, 2'b00})
            begin errors++; $display("FAIL sub_borrow got %h %b exp fffffffa 00", bus.result, {bus.carry, bus.ovf}); end
    endtask

    task automatic test_logic_slt();
        int c;
        load(1, 32'hF0F0_1234); load(2, 32'h0FF0_FF00);
        run_op(c_op_and, 1, 2, 0, 1'b0, 1'b0, c);
        checks++; if (bus.result !== 32'h00F0_1200) begin errors++; $display("FAIL and got %h exp 00f01200", bus.result); end
        run_op(c_op_xor, 1, 2, 0, 1'b0, 1'b0, c);
        checks++; if (bus.result !== 32'hFF00_ED34) begin errors++; $display("FAIL xor got %h exp ff00ed34", bus.result); end
        load(1, 32'hFFFF_FFFF); load(2, 32'd1);
        run_op(c_op_sltu, 1, 2, 0, 1'b0, 1'b0, c);
        checks++; if ({bus.result, bus.zero} !== {32'd0, 1'b1}) begin errors++; $display("FAIL sltu got %h z%b exp 0 z1", bus.result, bus.zero); end
        run_op(c_op_slts, 1, 2, 0, 1'b0, 1'b0, c);
        checks++; if ({bus.result, bus.zero} !== {32'd1, 1'b0}) begin errors++; $display("FAIL slts got %h z%b exp 1 z0", bus.result, bus.zero); end
    endtask

    task automatic test_illegal();
        int c;
        logic [31:0] d;
        load(3, 32'h0000_1234);
        run_op(c_op_rsvd, 1, 2, 3, 1'b1, 1'b0, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL rsvd_latency got %0d exp 1", c); end
        checks++; if ({bus.result, bus.zero, bus.illegal} !== {32'd0, 2'b11})
            begin errors++; $display("FAIL rsvd_result got %h %b exp 0 11", bus.result, {bus.zero, bus.illegal}); end
        read_reg(3, d);
        checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL rsvd_nowrite got %h exp 1234", d); end
    endtask

    task automatic test_mul();
        int c;
        logic [31:0] d;
        load(1, 32'h0001_0000); load(2, 32'h0001_0001); load(3, 32'h0000_1234);
`ifdef MC_DATAPATH_MUL_EN
        run_op(c_op_mul, 1, 2, 3, 1'b1, 1'b1, c);
        checks++; if (c !== WIDTH) begin errors++; $display("FAIL mul_latency got %0d exp %0d", c, WIDTH); end
        checks++; if ({bus.result, bus.zero, bus.illegal} !== {32'h0001_0000, 2'b00})
            begin errors++; $display("FAIL mul_result got %h %b exp 00010000 00", bus.result, {bus.zero, bus.illegal}); end
        tick();
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL mul_single_done got %b exp 00", {bus.done, bus.busy}); end
        read_reg(3, d);
        checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL mul_writeback got %h exp 00010000", d); end
`else
        run_op(c_op_mul, 1, 2, 3, 1'b1, 1'b0, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL mul_off_latency got %0d exp 1", c); end
        checks++; if ({bus.result, bus.zero, bus.illegal} !== {32'd0, 2'b11})
            begin errors++; $display("FAIL mul_off_result got %h %b exp 0 11", bus.result, {bus.zero, bus.illegal}); end
        read_reg(3, d);
        checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL mul_off_nowrite got %h exp 1234", d); end
`endif
    endtask

    // Load on the accepting edge: operands must be the pre-load values
    task automatic test_same_edge_load();
        logic [31:0] d;
        load(1, 32'd3);
        bus.op = c_op_add; bus.addr1 = 2'd1; bus.addr2 = 2'd1; bus.addr3 = 2'd2; bus.wr = 1'b1;
        bus.ld_en = 1'b1; bus.ld_addr = 2'd1; bus.ld_data = 32'd100;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.ld_en = 1'b0; bus.wr = 1'b0;
        tick();
        checks++; if ({bus.done, bus.result} !== {1'b1, 32'd6}) begin errors++; $display("FAIL same_edge_result got %b %h exp 1 6", bus.done, bus.result); end
        read_reg(1, d);
        checks++; if (d !== 32'd100) begin errors++; $display("FAIL same_edge_load got %h exp 64", d); end
        read_reg(2, d);
        checks++; if (d !== 32'd6) begin errors++; $display("FAIL same_edge_wb got %h exp 6", d); end
    endtask

    task automatic test_load_while_busy();
        logic [31:0] d;
        load(0, 32'h55);
        bus.op = c_op_add; bus.addr1 = 2'd0; bus.addr2 = 2'd0; bus.addr3 = 2'd1; bus.wr = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got %b exp 1", bus.busy); end
        bus.ld_en = 1'b1; bus.ld_addr = 2'd0; bus.ld_data = 32'hDEAD;
        tick();
        bus.ld_en = 1'b0;
        checks++; if (bus.result !== 32'hAA) begin errors++; $display("FAIL busy_op_result got %h exp aa", bus.result); end
        read_reg(0, d);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL load_while_busy got %h exp 55", d); end
    endtask

    task automatic test_abort();
        int seen;
        logic [31:0] d;
        load(0, 32'h11); load(1, 32'h0001_0000); load(2, 32'h0001_0001); load(3, 32'h33);
`ifdef MC_DATAPATH_MUL_EN
        bus.op = c_op_mul;
`else
        bus.op = c_op_add;
`endif
        bus.addr1 = 2'd1; bus.addr2 = 2'd2; bus.addr3 = 2'd3; bus.wr = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
`ifdef MC_DATAPATH_MUL_EN
        for (int i = 0; i < 9; i++) tick();
`endif
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL abort_busy got %b exp 00", {bus.busy, bus.done}); end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_done_pulses got %0d exp 0", seen); end
        for (int r = 0; r < NREGS; r++) begin
            read_reg(r, d);
            checks++; if (d !== 32'd0) begin errors++; $display("FAIL abort_reg%0d got %h exp 0", r, d); end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.addr1 = '0; bus.addr2 = '0; bus.addr3 = '0;
        bus.wr = 1'b0; bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        test_reset();
        test_add();
        test_arith_flags();
        test_logic_slt();
        test_illegal();
        test_mul();
        test_same_edge_load();
        test_load_while_busy();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
